max_unpool_2x2: RTL and testbench
=================================

# max_unpool_2x2

Inverse of the 2x2 max-pooling stage. Takes a pooled feature map plus the per-window argmax index recorded during pooling. Scatters each pooled value back to its original position in a zero-filled full-resolution map, one window per enabled clock. Sits in the decoder/backward path of the CNN, consuming the channel-major, row-major flattened layout the pooling stage produces.

## Interface

Parameters:
- BITWIDTH, 16, bits per data element
- DATAWIDTH, 8, full-resolution map width; must be even
- DATAHEIGHT, 8, full-resolution map height; must be even
- DATACHANNEL, 3, number of channels
- Derived: OW = DATAWIDTH/2, OH = DATAHEIGHT/2, N = OW*OH*DATACHANNEL

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clken  in  1  global enable; low freezes all state and outputs
- start  in  1  single-cycle request; sampled only in IDLE with clken=1
- pooled_in  in  BITWIDTH*N  pooled map; element k at bits [k*BITWIDTH +: BITWIDTH], k = c*OH*OW + r*OW + q
- idx_in  in  2*N  argmax per element k at [k*2 +: 2]: 0=(2r,2q), 1=(2r,2q+1), 2=(2r+1,2q), 3=(2r+1,2q+1)
- data_out  out  BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL  full map; element at [(c*DATAHEIGHT*DATAWIDTH + y*DATAWIDTH + x)*BITWIDTH +: BITWIDTH]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when data_out is complete

## Operation

- States: IDLE, CLEAR, RUN.
- IDLE: on start=1 and clken=1, latch pooled_in and idx_in into internal registers. Go to CLEAR; busy<=1. Inputs may change afterwards.
- CLEAR: data_out <= 0 (all bits); zero counters c, r, q and k. Go to RUN.
- RUN, per enabled cycle, for element k at (c, r, q):
  - write the latched value to the full-map position selected by its index;
  - write 0 to the other three positions of that window;
  - advance q, wrapping at OW-1 to 0 with r++; r wraps at OH-1 to 0 with c++.
  - On k = N-1 the write completes as usual; then busy<=0, done<=1, go to IDLE.
- done is cleared on the next enabled cycle.
- data_out holds its final value until the next accepted start's CLEAR cycle.
- start while busy: ignored, no queueing.
- start in the same cycle done is high: accepted, since the FSM is already IDLE.
- No arithmetic. Values are copied bit-exact, with no sign interpretation. A pooled value of 0 is indistinguishable from fill.
- Counters are sized by $clog2 of their bound, minimum 1 bit.

## Timing

- Reset values: data_out=0, busy=0, done=0, state=IDLE, counters=0, latched inputs=0.
- Enabled edge E0 samples start. Edge E1 runs CLEAR. Edges E2..E(N+1) write elements 0..N-1.
- done is high in the cycle after E(N+1). Latency start->done is N+2 enabled cycles; N=48 at defaults gives 50.
- clken=0 cycles insert stalls with no state change; done stays high across stalls until the next enabled edge.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). No done is produced; a new start is required.

## Test plan

- Defaults, all idx=0, pooled value k+1 for element k: data_out(c,2r,2q)=k+1, all other positions 0. done after exactly 50 cycles; busy high for cycles 1-49 after start.
- Element 0 = 0xABCD with idx 0,1,2,3 on four successive runs: 0xABCD lands at x,y = (0,0), (1,0), (0,1), (1,1) respectively; the other three positions are 0.
- Random pooled/idx, then pass data_out through the max-pool stage: recovered map equals pooled_in whenever values are nonzero.
- clken toggled 50% during a run, and pooled_in changed after start: final data_out matches the start-time inputs; done delayed by exactly the number of low-clken cycles.
- start pulsed at cycle 10 of a run: ignored, busy unaffected, single done.
- start coincident with done: second run begins, and data_out reads all-zero after its CLEAR.
- rst_n pulsed low at cycle 20: data_out=0, busy=0 and done=0 immediately; no done follows until a new start.

Source files
------------

// File: rtl/max_unpool_2x2.sv
// Inverse of 2x2 max pooling: scatters each latched pooled value to the window
// position given by its argmax index, zero-filling the rest, one window per enabled clock.
module max_unpool_2x2 #(
  parameter  int BITWIDTH    = 16,
  parameter  int DATAWIDTH   = 8,
  parameter  int DATAHEIGHT  = 8,
  parameter  int DATACHANNEL = 3,
  localparam int OW          = DATAWIDTH / 2,
  localparam int OH          = DATAHEIGHT / 2,
  localparam int N           = OW * OH * DATACHANNEL,
  localparam int TOT         = DATAWIDTH * DATAHEIGHT * DATACHANNEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clken,
  input  logic                    start,
  input  logic [BITWIDTH*N-1:0]   pooled_in,
  input  logic [2*N-1:0]          idx_in,
  output logic [BITWIDTH*TOT-1:0] data_out,
  output logic                    busy,
  output logic                    done
);

  localparam int PLANE = DATAWIDTH * DATAHEIGHT;
  localparam int CW    = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;
  localparam int RW    = (OH > 1) ? $clog2(OH) : 1;
  localparam int QW    = (OW > 1) ? $clog2(OW) : 1;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN
  } state_t;

  state_t                  r_state;
  logic [BITWIDTH*N-1:0]   r_pooled;
  logic [2*N-1:0]          r_idx;
  logic [BITWIDTH*TOT-1:0] r_data;
  logic                    r_busy;
  logic                    r_done;
  logic [CW-1:0]           r_c;
  logic [RW-1:0]           r_r;
  logic [QW-1:0]           r_q;
  logic [KW-1:0]           r_k;

  logic [BITWIDTH-1:0]     w_val;
  logic [1:0]              w_sel;
  int                      w_base;
  int                      w_off [4];
  logic [BITWIDTH-1:0]     w_wr  [4];

  // Window slot i is (dy, dx) = (i/2, i%2), which is exactly the argmax encoding.
  // NOTE: every always_comb output gets a default assignment up front, so no path can infer a latch.
  always_comb begin
    w_val  = r_pooled[int'(r_k)*BITWIDTH +: BITWIDTH];
    w_sel  = r_idx[int'(r_k)*2 +: 2];
    w_base = int'(r_c) * PLANE + int'(r_r) * 2 * DATAWIDTH + int'(r_q) * 2;
    for (int i = 0; i < 4; i++) begin
      w_off[i] = (w_base + (i / 2) * DATAWIDTH + (i % 2)) * BITWIDTH;
      w_wr[i]  = (w_sel == 2'(i)) ? w_val : '0;
    end
  end

  // NOTE: state is written with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide latches and output map are reset too, because reset must visibly clear data_out.
      r_state  <= S_IDLE;
      r_pooled <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_k      <= '0;
    end else if (clken) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pooled <= pooled_in;
            r_idx    <= idx_in;
            r_busy   <= 1'b1;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_data  <= '0;
          r_c     <= '0;
          r_r     <= '0;
          r_q     <= '0;
          r_k     <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          for (int i = 0; i < 4; i++) begin
            r_data[w_off[i] +: BITWIDTH] <= w_wr[i];
          end
          r_k <= r_k + KW'(1);
          if (r_q == QW'(OW - 1)) begin
            r_q <= '0;
            if (r_r == RW'(OH - 1)) begin
              r_r <= '0;
              r_c <= r_c + CW'(1);
            end else begin
              r_r <= r_r + RW'(1);
            end
          end else begin
            r_q <= r_q + QW'(1);
          end
          if (r_k == KW'(N - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_max_unpool_2x2.sv
// Directed self-checking bench for max_unpool_2x2 at default parameters.
module tb_max_unpool_2x2;

  localparam int BW  = 16;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int C   = 3;
  localparam int N   = (W / 2) * (H / 2) * C;
  localparam int TOT = W * H * C;
  localparam int PW  = BW * N;
  localparam int IW  = 2 * N;
  localparam int DW  = BW * TOT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clken;
  logic          start;
  logic [PW-1:0] pooled_in;
  logic [IW-1:0] idx_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  max_unpool_2x2 #(
    .BITWIDTH(BW), .DATAWIDTH(W), .DATAHEIGHT(H), .DATACHANNEL(C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clken(clken), .start(start),
    .pooled_in(pooled_in), .idx_in(idx_in),
    .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int e = 0; e < TOT; e++)
      if (a[e*BW +: BW] !== b[e*BW +: BW]) return e;
    return -1;
  endfunction

  task automatic check_map(input string tag, input logic [DW-1:0] exp);
    int e;
    n_vec++;
    assert (data_out === exp) else begin
      n_err++;
      e = first_diff(data_out, exp);
      $error("FAIL %s: element %0d observed %0h expected %0h", tag, e,
             data_out[e*BW +: BW], exp[e*BW +: BW]);
    end
  endtask

  function automatic logic [BW-1:0] elem(input logic [DW-1:0] m, input int c, input int y, input int x);
    return m[(c*H*W + y*W + x)*BW +: BW];
  endfunction

  // Reference scatter: element k at (c, r, q) goes to (2r + idx[1], 2q + idx[0]).
  function automatic logic [DW-1:0] unpool_model(input logic [PW-1:0] p, input logic [IW-1:0] ix);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      int c, r, q, y, x;
      c = k / ((W / 2) * (H / 2));
      r = (k / (W / 2)) % (H / 2);
      q = k % (W / 2);
      y = 2 * r + int'(ix[2*k+1]);
      x = 2 * q + int'(ix[2*k]);
      m[(c*H*W + y*W + x)*BW +: BW] = p[k*BW +: BW];
    end
    return m;
  endfunction

  task automatic start_pulse();
    clken = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits for done, optionally dropping clken on every other edge.
  task automatic wait_done(input bit toggle, output int edges, output int stalls, output int busy_lows);
    edges = 0; stalls = 0; busy_lows = 0;
    while (done !== 1'b1 && edges < 400) begin
      clken = toggle ? edges[0] : 1'b1;
      if (!clken) stalls++;
      step();
      edges++;
      if (done !== 1'b1 && busy !== 1'b1) busy_lows++;
    end
    clken = 1'b1;
  endtask

  logic [PW-1:0] p_a, p_b, p_c;
  logic [IW-1:0] i_a, i_b, i_c;
  logic [DW-1:0] m_exp;
  int edges, stalls, busy_lows, dones, bad_val, bad_idx;
  logic [15:0] tmp16;

  initial begin
    rst_n = 1'b0; clken = 1'b0; start = 1'b0; pooled_in = '0; idx_in = '0;
    for (int k = 0; k < N; k++) begin
      p_a[k*BW +: BW] = 16'(k + 1);
      i_a[2*k +: 2]   = 2'd0;
      p_b[k*BW +: BW] = 16'(16'h8000 + k * 3);
      i_b[2*k +: 2]   = 2'((k + 2) % 4);
      tmp16 = 16'(k * 16'h9E37 + 16'h1234);
      p_c[k*BW +: BW] = tmp16 | 16'h0001;
      i_c[2*k +: 2]   = 2'((k * 7 + k / 5) % 4);
    end

    #12;
    check("reset_data", 32'(data_out != '0), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run 1: idx all 0, values k+1.
    pooled_in = p_a; idx_in = i_a;
    start_pulse();
    check("r1_busy_after_start", 32'(busy), 32'd1);
    wait_done(1'b0, edges, stalls, busy_lows);
    check("r1_latency_edges", 32'(edges), 32'd49);
    check("r1_busy_gaps", 32'(busy_lows), 32'd0);
    check("r1_busy_at_done", 32'(busy), 32'd0);
    check_map("r1_map", unpool_model(p_a, i_a));
    check("r1_elem_c1_y2_x4", 32'(elem(data_out, 1, 2, 4)), 32'h17);
    check("r1_elem_c1_y3_x5", 32'(elem(data_out, 1, 3, 5)), 32'h0);
    clken = 1'b0;
    step(); step();
    check("r1_done_held_stall", 32'(done), 32'd1);
    clken = 1'b1;
    step();
    check("r1_done_cleared", 32'(done), 32'd0);

    // Runs 2-5: element 0 = 0xABCD with each argmax index.
    for (int i = 0; i < 4; i++) begin
      pooled_in = '0;
      pooled_in[0 +: BW] = 16'hABCD;
      idx_in = '0;
      idx_in[1:0] = 2'(i);
      m_exp = unpool_model(pooled_in, idx_in);
      start_pulse();
      wait_done(1'b0, edges, stalls, busy_lows);
      check($sformatf("idx%0d_latency", i), 32'(edges), 32'd49);
      check($sformatf("idx%0d_hit", i), 32'(elem(data_out, 0, i / 2, i % 2)), 32'hABCD);
      check_map($sformatf("idx%0d_map", i), m_exp);
    end

    // Run 6: clken toggled, inputs changed after start, then max-pool round trip.
    pooled_in = p_c; idx_in = i_c;
    start_pulse();
    pooled_in = ~p_c; idx_in = ~i_c;
    wait_done(1'b1, edges, stalls, busy_lows);
    check("stall_stall_count", 32'(stalls), 32'd49);
    check("stall_latency", 32'(edges - stalls), 32'd49);
    check_map("stall_map", unpool_model(p_c, i_c));
    bad_val = 0; bad_idx = 0;
    for (int k = 0; k < N; k++) begin
      int c, r, q, best_i;
      logic [BW-1:0] best, v;
      c = k / ((W / 2) * (H / 2));
      r = (k / (W / 2)) % (H / 2);
      q = k % (W / 2);
      best = '0; best_i = 0;
      for (int j = 0; j < 4; j++) begin
        v = elem(data_out, c, 2 * r + j / 2, 2 * q + j % 2);
        if (v > best) begin best = v; best_i = j; end
      end
      if (best !== p_c[k*BW +: BW]) bad_val++;
      if (2'(best_i) !== i_c[2*k +: 2]) bad_idx++;
    end
    check("roundtrip_values", 32'(bad_val), 32'd0);
    check("roundtrip_indices", 32'(bad_idx), 32'd0);

    // Run 7: extra start at cycle 10 is ignored.
    pooled_in = p_a; idx_in = i_a;
    start_pulse();
    repeat (9) step();
    pooled_in = p_b; idx_in = i_b;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_ignored", 32'(busy), 32'd1);
    wait_done(1'b0, edges, stalls, busy_lows);
    check("busy_start_latency", 32'(edges), 32'd39);
    check_map("busy_start_map", unpool_model(p_a, i_a));
    step();
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    check("busy_start_no_second_done", 32'(dones), 32'd0);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Run 8 then 9: start coincident with done.
    pooled_in = p_a; idx_in = i_a;
    start_pulse();
    wait_done(1'b0, edges, stalls, busy_lows);
    check("b2b_first_done", 32'(done), 32'd1);
    pooled_in = p_b; idx_in = i_b;
    start_pulse();
    check("b2b_accepted_busy", 32'(busy), 32'd1);
    check("b2b_done_cleared", 32'(done), 32'd0);
    step();
    check("b2b_cleared_map", 32'(data_out != '0), 32'd0);
    wait_done(1'b0, edges, stalls, busy_lows);
    check("b2b_latency", 32'(edges), 32'd48);
    check_map("b2b_map", unpool_model(p_b, i_b));

    // Run 10: asynchronous reset at cycle 20.
    pooled_in = p_c; idx_in = i_c;
    start_pulse();
    repeat (19) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", 32'(data_out != '0), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
    check("rst_stays_idle", 32'(busy), 32'd0);
    start_pulse();
    wait_done(1'b0, edges, stalls, busy_lows);
    check("rst_restart_latency", 32'(edges), 32'd49);
    check_map("rst_restart_map", unpool_model(p_c, i_c));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
